// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: default widths,
// wrap/saturate mode selectors and direction encodings.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEF = 8;
    localparam int EVT_WIDTH_DEF     = 8;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/updown_counter_mod_bit_reverse.sv
// bit_reverse_param: purely combinational bit-order reversal of a WIDTH-bit bus,
// used to present the counter value MSB-first to downstream blocks.
module bit_reverse_param #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign data_o[i] = data_i[WIDTH-1-i];
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, programmable modulus, wrap or saturate
// mode, boundary pulses and a saturating event tally. Optional reversed-count
// output is enabled by defining UPDOWN_COUNTER_REVERSE_OUT_EN.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH     = COUNTER_WIDTH_DEF,
    parameter int MOD_VALUE = (1 << WIDTH) - 1,
    parameter int SATURATE  = CNT_MODE_WRAP,
    parameter int EVT_WIDTH = EVT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     load_val_i,
    input  logic                 up_i,
    output logic [WIDTH-1:0]     counter_o,
    output logic                 tc_o,
    output logic                 ov_o,
    output logic                 uf_o,
    output logic [EVT_WIDTH-1:0] evt_cnt_o
`ifdef UPDOWN_COUNTER_REVERSE_OUT_EN
    ,
    output logic [WIDTH-1:0]     counter_rev_o
`endif
);

    localparam logic [WIDTH-1:0]     MOD_W    = WIDTH'(MOD_VALUE);
    localparam logic [EVT_WIDTH-1:0] EVT_MAX  = '1;
    localparam bit                   SAT_MODE = (SATURATE == CNT_MODE_SAT);

    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be at least 2");
    end
    if (MOD_VALUE < 0 || MOD_VALUE > (1 << WIDTH) - 1) begin : g_bad_mod
        $error("updown_counter_mod: MOD_VALUE out of range for WIDTH");
    end

    logic [WIDTH-1:0]     count_q, count_d;
    logic                 ov_q, ov_d;
    logic                 uf_q, uf_d;
    logic [EVT_WIDTH-1:0] evt_q, evt_d;
    logic                 at_top, at_bot;

    assign at_top = (count_q == MOD_W);
    assign at_bot = (count_q == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            ov_q    <= 1'b0;
            uf_q    <= 1'b0;
            evt_q   <= '0;
        end else begin
            count_q <= count_d;
            ov_q    <= ov_d;
            uf_q    <= uf_d;
            evt_q   <= evt_d;
        end
    end

    // Boundary pulses are computed alongside the count so the tally bumps on
    // the same edge the pulse is registered.
    always_comb begin
        count_d = count_q;
        ov_d    = 1'b0;
        uf_d    = 1'b0;
        evt_d   = evt_q;
        if (clr_i) begin
            count_d = '0;
            evt_d   = '0;
        end else if (load_i) begin
            count_d = (load_val_i > MOD_W) ? MOD_W : load_val_i;
        end else if (en_i) begin
            if (up_i == DIR_UP) begin
                if (at_top) begin
                    ov_d    = 1'b1;
                    count_d = SAT_MODE ? count_q : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_bot) begin
                    uf_d    = 1'b1;
                    count_d = SAT_MODE ? count_q : MOD_W;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            if ((ov_d || uf_d) && (evt_q != EVT_MAX)) begin
                evt_d = evt_q + 1'b1;
            end
        end
    end

    assign counter_o = count_q;
    assign ov_o      = ov_q;
    assign uf_o      = uf_q;
    assign evt_cnt_o = evt_q;
    assign tc_o      = (up_i == DIR_UP) ? at_top : at_bot;

`ifdef UPDOWN_COUNTER_REVERSE_OUT_EN
    bit_reverse_param #(
        .WIDTH (WIDTH)
    ) u_rev (
        .data_i (count_q),
        .data_o (counter_rev_o)
    );
`endif

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised successor to the team's 8-bit enable/clear counter.
- Adds up/down direction, synchronous load, a programmable modulus, and a wrap or saturate mode.
- Adds registered overflow/underflow pulses and a saturating wrap-event tally.
- Sits in the same test/demo datapath, driving downstream bit-manipulation blocks such as the bit reverser.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MOD_VALUE, 2**WIDTH-1, terminal count; counter range is 0..MOD_VALUE (must be <= 2**WIDTH-1).
- SATURATE, 0, 0 = wrap at the range ends; 1 = hold at 0 or MOD_VALUE.
- EVT_WIDTH, 8, width of the wrap/saturate event tally.

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- EN  input  1  count enable.
- CLR  input  1  synchronous clear of counter, flags and tally.
- LOAD  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- counter  output  WIDTH  registered count.
- TC  output  1  combinational; 1 when (UP && counter==MOD_VALUE) or (!UP && counter==0).
- OV  output  1  registered one-cycle pulse on an upward boundary event.
- UF  output  1  registered one-cycle pulse on a downward boundary event.
- evt_cnt  output  EVT_WIDTH  count of OV+UF events; saturates at all-ones.

Behaviour:
- Reset low, asynchronous: counter=0, OV=0, UF=0, evt_cnt=0. Reset asserted mid-count aborts immediately. The first count happens on the first rising clk edge after Reset goes high with EN=1.
- Priority per rising edge: CLR > LOAD > EN > hold.
- CLR: counter=0, OV=0, UF=0, evt_cnt=0.
- LOAD:
  - counter = min(load_val, MOD_VALUE).
  - OV=UF=0; evt_cnt unchanged.
  - LOAD with EN in the same cycle: load wins, no count.
- EN with UP=1:
  - counter < MOD_VALUE: counter+1, OV=0.
  - counter == MOD_VALUE: OV=1 for one cycle; counter goes to 0 if SATURATE=0, holds if SATURATE=1.
- EN with UP=0:
  - counter > 0: counter-1, UF=0.
  - counter == 0: UF=1 for one cycle; counter goes to MOD_VALUE if SATURATE=0, holds 0 if SATURATE=1.
- EN=0 (and no CLR/LOAD): counter holds; OV=UF=0.
- OV and UF are mutually exclusive and never asserted in back-to-back cycles unless another boundary event occurs.
- In saturate mode, each blocked attempt at a boundary pulses OV or UF again.
- evt_cnt: +1 in the cycle OV or UF is registered high (same edge as the boundary event). Holds at 2**EVT_WIDTH-1.
- Latency: one clock from qualified input to counter, OV, UF and evt_cnt. TC has zero latency from counter.
- UP may change any cycle; a direction reversal at a boundary follows the UP value sampled on that edge.
- All arithmetic is modulo WIDTH bits internally. A value outside 0..MOD_VALUE is unreachable except via a clamped load.

Optional Feature:
- UPDOWN_COUNTER_REVERSE_OUT_EN defined: adds output port counter_rev [WIDTH-1:0], a combinational bit-reverse of counter (counter_rev[i] = counter[WIDTH-1-i]), built by instantiating the sub-module.
- Undefined: the port and instance are absent; all other behaviour is identical.

Decomposition:
- Shared package counter_pkg:
  - localparam defaults: COUNTER_WIDTH_DEF=8, EVT_WIDTH_DEF=8.
  - Mode constants: CNT_MODE_WRAP=0, CNT_MODE_SAT=1.
  - Direction constants: DIR_DOWN=0, DIR_UP=1.
- One sub-module, bit_reverse_param (parameter WIDTH): pure combinational concatenation/generate reversal, used only under the macro.
- Counter next-state and event logic stay in one always block set in the top.

Test Plan:
- Reset/start: hold Reset=0 for 14 time units with EN=1, UP=1, WIDTH=8 -> counter=0, OV=UF=0, evt_cnt=0; after release, counter reads 1,2,3 on successive edges.
- Up wrap: MOD_VALUE=9, SATURATE=0, count up from 0 -> sequence 0..9, then 0 with OV=1 for exactly one cycle and evt_cnt=1; TC=1 while counter=9.
- Down wrap and saturate:
  - SATURATE=0, LOAD load_val=0, UP=0, EN=1 -> next counter=MOD_VALUE, UF=1.
  - SATURATE=1, same stimulus -> counter stays 0, UF pulses every cycle, evt_cnt increments each cycle.
- Priority/clamp:
  - MOD_VALUE=9, LOAD=1 with load_val=200 and EN=1 -> counter=9, no OV.
  - CLR=1 with LOAD=1 -> counter=0, evt_cnt=0.
- Async reset mid-run: counter=0x5A, drop Reset between edges -> counter=0 immediately, before the next clk edge.
- Tally saturation: EVT_WIDTH=2, force 5 wraps -> evt_cnt reads 1,2,3,3,3. With UPDOWN_COUNTER_REVERSE_OUT_EN defined, counter=8'h01 -> counter_rev=8'h80.
